// File: rtl/rbfu_ctrl.sv
// rtl/rbfu_ctrl.sv - issue/writeback address sequencer for a dual-butterfly NTT/INTT/PWM unit
// Walks 64 beats per layer, drains the RBFU pipe between layers, delays addresses to writeback.
module rbfu_ctrl #(
  parameter int WB_LAT = 3,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          stall,
  output logic [AW-1:0] rd_a0,
  output logic [AW-1:0] rd_b0,
  output logic [AW-1:0] rd_a1,
  output logic [AW-1:0] rd_b1,
  output logic [6:0]    tw_idx0,
  output logic [6:0]    tw_idx1,
  output logic [1:0]    opcode,
  output logic          issue_valid,
  output logic [AW-1:0] wr_addr0,
  output logic [AW-1:0] wr_addr1,
  output logic [AW-1:0] wr_addr2,
  output logic [AW-1:0] wr_addr3,
  output logic          wr_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  localparam logic [3:0] LAST_D = 4'(WB_LAT - 1);
  localparam int         PW     = 4 * AW + 1;

  state_t     state;
  logic [5:0] cnt;
  logic [2:0] layer;
  logic [3:0] dcnt;
  logic [2:0] last_layer;

  logic [2:0] s_sh;
  logic [6:0] i0, i1;
  logic [7:0] na0, nb0, na1, nb1;
  logic [6:0] nt0, nt1;

  logic [PW-1:0] pipe [WB_LAT];

  // Lower index of the butterfly: insert a zero bit at position s of i.
  function automatic logic [7:0] bf_a(input logic [6:0] i, input logic [2:0] s);
    logic [7:0] w;
    w = {1'b0, i};
    return ((w >> s) << ({1'b0, s} + 4'd1)) | (w & ((8'd1 << s) - 8'd1));
  endfunction

  function automatic logic [6:0] bf_tw(input logic [6:0] i, input logic [2:0] s,
                                       input logic [2:0] l, input logic inv);
    logic [7:0] q;
    logic [7:0] r;
    q = {1'b0, i} >> s;
    if (inv) r = (8'd128 >> l) - 8'd1 - q;
    else     r = (8'd1 << l) + q;
    return r[6:0];
  endfunction

  assign last_layer  = opcode[1] ? 3'd0 : 3'd6;
  assign issue_valid = (state == ST_ISSUE) && !stall;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

  always_comb begin
    s_sh    = opcode[0] ? (layer + 3'd1) : (3'd7 - layer);
    i0      = {cnt, 1'b0};
    i1      = {cnt, 1'b1};
    na0     = bf_a(i0, s_sh);
    na1     = bf_a(i1, s_sh);
    nb0     = na0 + (8'd1 << s_sh);
    nb1     = na1 + (8'd1 << s_sh);
    nt0     = bf_tw(i0, s_sh, layer, opcode[0]);
    nt1     = bf_tw(i1, s_sh, layer, opcode[0]);
    rd_a0   = '0;
    rd_b0   = '0;
    rd_a1   = '0;
    rd_b1   = '0;
    tw_idx0 = '0;
    tw_idx1 = '0;
    // Addresses are a pure function of cnt/layer, so a stall holds them for free.
    if (state == ST_ISSUE) begin
      if (opcode[1]) begin
        rd_a0   = AW'({cnt, 2'b00});
        rd_b0   = AW'({cnt, 2'b01});
        rd_a1   = AW'({cnt, 2'b10});
        rd_b1   = AW'({cnt, 2'b11});
        tw_idx0 = {1'b1, cnt};
        tw_idx1 = {1'b1, cnt};
      end else begin
        rd_a0   = AW'(na0);
        rd_b0   = AW'(nb0);
        rd_a1   = AW'(na1);
        rd_b1   = AW'(nb1);
        tw_idx0 = nt0;
        tw_idx1 = nt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      layer  <= '0;
      dcnt   <= '0;
      opcode <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opcode <= mode;
            cnt    <= '0;
            layer  <= '0;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              dcnt  <= '0;
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt == LAST_D) begin
            if (layer == last_layer) begin
              state <= ST_DONE;
            end else begin
              layer <= layer + 3'd1;
              state <= ST_ISSUE;
            end
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        ST_DONE: begin
          layer <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WB_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {issue_valid, rd_a0, rd_b0, rd_a1, rd_b1};
      for (int k = 1; k < WB_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign {wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3} = pipe[WB_LAT-1];

endmodule
